// File: rtl/spi_pkg.sv
// Shared SPI definitions for spi_master and spi_slave: FSM states, widths and mode constants.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

    localparam int SPI_DATA_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    // Mode 0: sck idles low, data sampled on the rising sck edge
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master; the count restarts whenever en drops.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// Byte-wide mode-0 SPI master with start/done handshake.
// Define SPI_MASTER_LSB_FIRST_EN to send and receive LSB first; timing is unchanged.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              ss,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    spi_state_e state, state_next;

    logic                     tick;
    logic                     div_en;
    logic                     last_fall;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]        shreg;
    logic [DATA_W-1:0]        shift_in;
    logic                     next_bit;
    logic                     first_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign shift_in  = {miso, shreg[DATA_W-1:1]};
    assign next_bit  = shreg[0];
    assign first_bit = din[0];
`else
    assign shift_in  = {shreg[DATA_W-2:0], miso};
    assign next_bit  = shreg[DATA_W-1];
    assign first_bit = din[DATA_W-1];
`endif

    assign div_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign busy   = div_en;
    assign done   = (state == DONE);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // SHIFT ends one low half-period after the 8th falling edge, giving 16 half-periods in SHIFT
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick) state_next = SHIFT;
            SHIFT:   if (tick && !sck && last_fall) state_next = HOLD;
            HOLD:    if (tick) state_next = DONE;
            DONE:    state_next = start ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss        <= 1'b1;
            sck       <= CPOL;
            mosi      <= 1'b0;
            dout      <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            last_fall <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        shreg     <= din;
                        ss        <= 1'b0;
                        mosi      <= first_bit;
                        bit_cnt   <= '0;
                        last_fall <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sck   <= 1'b1;
                        shreg <= shift_in;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sck) begin
                            sck <= 1'b0;
                            if (bit_cnt == '1) begin
                                last_fall <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + SPI_BIT_CNT_W'(1);
                                mosi    <= next_bit;
                            end
                        end else if (!last_fall) begin
                            sck   <= 1'b1;
                            shreg <= shift_in;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        ss   <= 1'b1;
                        mosi <= 1'b0;
                        dout <= shreg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
